// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with an iterative restoring divider.
// Single-cycle opcodes go through a one-deep operand stage and reach the
// output one edge after acceptance. DIV/MOD with a non-zero divisor run
// DATA_W shift-subtract iterations, then take one more edge to the output.
// Optional build macro: ALU_SIGNED_CMP_EN. When it is defined, 0xA/0xB
// compare signed and 0x4 is an arithmetic shift right.
module alu_seq #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_A,
  input  logic [DATA_W-1:0] IN_B,
  input  logic [3:0]        ALU_Op_Code,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] OUT_RESULT,
  output logic [3:0]        OUT_FLAGS
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_SHL  = 4'h3;
  localparam logic [3:0] OP_SHR  = 4'h4;
  localparam logic [3:0] OP_INCA = 4'h5;
  localparam logic [3:0] OP_INCB = 4'h6;
  localparam logic [3:0] OP_DECA = 4'h7;
  localparam logic [3:0] OP_DECB = 4'h8;
  localparam logic [3:0] OP_EQ   = 4'h9;
  localparam logic [3:0] OP_GT   = 4'hA;
  localparam logic [3:0] OP_LT   = 4'hB;
  localparam logic [3:0] OP_DIV  = 4'hC;
  localparam logic [3:0] OP_MOD  = 4'hD;
  localparam logic [3:0] OP_AND  = 4'hE;
  localparam logic [3:0] OP_OR   = 4'hF;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_DIVIDE = 1'b1;

  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

  logic [0:0]        state;

  // Operand stage for everything that completes in one cycle.
  logic              pend_valid;
  logic [3:0]        pend_op;
  logic [DATA_W-1:0] pend_a;
  logic [DATA_W-1:0] pend_b;

  // Divider: div_quo starts as the dividend and is shifted out MSB first
  // while quotient bits are shifted in at the bottom.
  logic [DATA_W-1:0] div_rem;
  logic [DATA_W-1:0] div_quo;
  logic [DATA_W-1:0] div_dsr;
  logic [CNT_W-1:0]  div_cnt;
  logic              div_is_mod;
  logic              div_done;

  logic              accept;
  logic              start_div;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W+1:0] div_diff;
  logic              div_ok;

  logic [DATA_W:0]     sum_ab;
  logic [DATA_W:0]     diff_ab;
  logic [2*DATA_W-1:0] prod_ab;
  logic                a_gt_b;
  logic                a_lt_b;
  logic                shr_fill;

  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              alu_div0;
  logic [DATA_W-1:0] res_nxt;
  logic              carry_nxt;
  logic              div0_nxt;

  assign IN_READY  = (state == ST_IDLE);
  assign accept    = IN_VALID && IN_READY;
  // A zero divisor never enters DIVIDE; it is answered by the 1-cycle path.
  assign start_div = accept && ((ALU_Op_Code == OP_DIV) || (ALU_Op_Code == OP_MOD))
                     && (IN_B != '0);

  assign div_shift = {div_rem, div_quo[DATA_W-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, div_dsr};
  assign div_ok    = ~div_diff[DATA_W+1];

  assign sum_ab  = {1'b0, pend_a} + {1'b0, pend_b};
  assign diff_ab = {1'b0, pend_a} - {1'b0, pend_b};
  assign prod_ab = {{DATA_W{1'b0}}, pend_a} * {{DATA_W{1'b0}}, pend_b};

`ifdef ALU_SIGNED_CMP_EN
  assign a_gt_b   = $signed(pend_a) > $signed(pend_b);
  assign a_lt_b   = $signed(pend_a) < $signed(pend_b);
  assign shr_fill = pend_a[DATA_W-1];
`else
  assign a_gt_b   = pend_a > pend_b;
  assign a_lt_b   = pend_a < pend_b;
  assign shr_fill = 1'b0;
`endif

  // Control FSM, operand capture and one restoring-division step per cycle.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RESET) begin
      state      <= ST_IDLE;
      pend_valid <= 1'b0;
      pend_op    <= '0;
      pend_a     <= '0;
      pend_b     <= '0;
      div_rem    <= '0;
      div_quo    <= '0;
      div_dsr    <= '0;
      div_cnt    <= '0;
      div_is_mod <= 1'b0;
      div_done   <= 1'b0;
    end else begin
      pend_valid <= accept && !start_div;
      div_done   <= 1'b0;
      if (accept) begin
        pend_op <= ALU_Op_Code;
        pend_a  <= IN_A;
        pend_b  <= IN_B;
      end
      case (state)
        ST_IDLE: begin
          if (start_div) begin
            state      <= ST_DIVIDE;
            div_rem    <= '0;
            div_quo    <= IN_A;
            div_dsr    <= IN_B;
            div_cnt    <= CNT_W'(DATA_W);
            div_is_mod <= (ALU_Op_Code == OP_MOD);
          end
        end
        default: begin
          div_quo <= {div_quo[DATA_W-2:0], div_ok};
          div_rem <= div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
          div_cnt <= div_cnt - 1'b1;
          // Last iteration: release the input side now; the result is
          // published on the following edge.
          if (div_cnt == CNT_W'(1)) begin
            state    <= ST_IDLE;
            div_done <= 1'b1;
          end
        end
      endcase
    end
  end

  // Single-cycle opcode decode from the operand stage.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_div0  = 1'b0;
    case (pend_op)
      OP_ADD:  begin alu_res = sum_ab[DATA_W-1:0];  alu_carry = sum_ab[DATA_W];  end
      OP_SUB:  begin alu_res = diff_ab[DATA_W-1:0]; alu_carry = diff_ab[DATA_W]; end
      OP_MUL:  begin
        alu_res   = prod_ab[DATA_W-1:0];
        alu_carry = |prod_ab[2*DATA_W-1:DATA_W];
      end
      OP_SHL:  begin alu_res = {pend_a[DATA_W-2:0], 1'b0}; alu_carry = pend_a[DATA_W-1]; end
      OP_SHR:  begin alu_res = {shr_fill, pend_a[DATA_W-1:1]}; alu_carry = pend_a[0]; end
      OP_INCA: begin alu_res = pend_a + ONE; alu_carry = (pend_a == ONES); end
      OP_INCB: begin alu_res = pend_b + ONE; alu_carry = (pend_b == ONES); end
      OP_DECA: begin alu_res = pend_a - ONE; alu_carry = (pend_a == '0);   end
      OP_DECB: begin alu_res = pend_b - ONE; alu_carry = (pend_b == '0);   end
      OP_EQ:   alu_res = {{(DATA_W-1){1'b0}}, pend_a == pend_b};
      OP_GT:   alu_res = {{(DATA_W-1){1'b0}}, a_gt_b};
      OP_LT:   alu_res = {{(DATA_W-1){1'b0}}, a_lt_b};
      // Only the zero-divisor case of DIV/MOD reaches the operand stage.
      OP_DIV:  begin alu_res = ONES;   alu_div0 = 1'b1; end
      OP_MOD:  begin alu_res = pend_a; alu_div0 = 1'b1; end
      OP_AND:  alu_res = pend_a & pend_b;
      OP_OR:   alu_res = pend_a | pend_b;
      default: alu_res = '0;
    endcase
  end

  // Select between a finished division and the single-cycle result.
  always_comb begin
    res_nxt   = alu_res;
    carry_nxt = alu_carry;
    div0_nxt  = alu_div0;
    if (div_done) begin
      res_nxt   = div_is_mod ? div_rem : div_quo;
      carry_nxt = 1'b0;
      div0_nxt  = 1'b0;
    end
  end

  // Output register: pulse OUT_VALID and hold result/flags until the next one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_VALID  <= 1'b0;
      OUT_RESULT <= '0;
      OUT_FLAGS  <= '0;
    end else begin
      OUT_VALID <= pend_valid || div_done;
      if (pend_valid || div_done) begin
        OUT_RESULT <= res_nxt;
        OUT_FLAGS  <= {div0_nxt, res_nxt[DATA_W-1], carry_nxt, (res_nxt == '0)};
      end
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the processor's 8-bit single-cycle ALU. Single-cycle operations are registered with 1-cycle latency. Adds an iterative shift-subtract divider/modulo, status flags (zero, carry, negative, divide-by-zero) and a valid/ready interface. Sits between the processor register file/decoder and the writeback path; the processor stalls on IN_READY low.

Parameters:
DATA_W, 8, operand/result width in bits (>= 4)
CNT_W, 4, divider iteration counter width; must satisfy 2^CNT_W > DATA_W

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET  input  1  synchronous, active-high reset
IN_VALID  input  1  operands and opcode valid this cycle
IN_READY  output  1  block can accept an operation (high only in IDLE)
IN_A  input  DATA_W  operand A
IN_B  input  DATA_W  operand B
ALU_Op_Code  input  4  operation select
OUT_VALID  output  1  one-cycle pulse: OUT_RESULT/flags updated
OUT_RESULT  output  DATA_W  result, held until next OUT_VALID
OUT_FLAGS  output  4  {DIV0, NEG, CARRY, ZERO}, held with OUT_RESULT

Behaviour:
- Interface: one clock; reset is synchronous and active-high (CLK, RESET as named above).
- Reset: state IDLE, IN_READY=1, OUT_VALID=0, OUT_RESULT=0, OUT_FLAGS=0, divider registers/counter cleared. RESET mid-division aborts; no OUT_VALID for the aborted op.
- Accept: transfer when IN_VALID && IN_READY; operands/opcode latched that edge. IN_VALID while IN_READY=0 is ignored (not queued).
- States: IDLE -> (accept non-divide op) IDLE, result next edge; IDLE -> (accept DIV/MOD, B!=0) DIVIDE; DIVIDE -> DIVIDE for DATA_W iterations -> IDLE with result. IN_READY=0 throughout DIVIDE.
- Latency: single-cycle ops accepted edge N -> OUT_VALID high after edge N+1 (back-to-back accepts give back-to-back OUT_VALID). DIV/MOD: OUT_VALID after edge N+DATA_W+1.
- Opcodes (all arithmetic modulo 2^DATA_W unless noted):
  0x0 A+B, CARRY=carry out; 0x1 A-B, CARRY=borrow (A<B); 0x2 A*B low DATA_W bits, CARRY=1 if high half nonzero;
  0x3 A<<1, CARRY=A[MSB]; 0x4 A>>1 logical, CARRY=A[0]; 0x5 A+1; 0x6 B+1; 0x7 A-1; 0x8 B-1 (CARRY = wrap on 0x5-0x8);
  0x9 A==B; 0xA A>B; 0xB A<B (unsigned; result 1 or 0 zero-extended);
  0xC A/B quotient; 0xD A%B remainder; 0xE A&B; 0xF A|B.
- Flags: ZERO = result==0; NEG = result[MSB]; CARRY per above, 0 for others; DIV0 = 1 only for 0xC/0xD with B==0.
- Divide by zero: no DIVIDE state; 1-cycle latency; 0xC returns all-ones, 0xD returns A, DIV0=1.
- Divider: restoring, one quotient bit per cycle, MSB first; counter counts DATA_W down to 0.

Optional Feature:
ALU_SIGNED_CMP_EN: when defined, opcode 0xA/0xB compare A,B as two's-complement signed, and 0x4 becomes arithmetic shift right (sign-preserving, CARRY=A[0]). When undefined, all comparisons unsigned and 0x4 logical. Other opcodes unaffected.

Test Plan:
- RESET high 2 cycles then low -> IN_READY=1, OUT_VALID=0, OUT_RESULT=0x00, OUT_FLAGS=0.
- ADD A=0xF0,B=0x20 -> next cycle OUT_VALID=1, OUT_RESULT=0x10, CARRY=1, ZERO=0; MUL 0x10*0x10 -> 0x00, CARRY=1, ZERO=1.
- Back-to-back: SUB 0x05-0x07 then CMP-EQ 0x33,0x33 on consecutive cycles -> results 0xFE (CARRY=1, NEG=1) then 0x01 on consecutive cycles.
- DIV A=200,B=7 -> IN_READY low 8 cycles, OUT_VALID exactly 9 cycles after accept, result 28; MOD same operands -> 4; IN_VALID asserted during DIVIDE ignored.
- DIV A=0x55,B=0 -> 1-cycle latency, OUT_RESULT=0xFF, DIV0=1; MOD -> 0x55, DIV0=1.
- RESET asserted 3 cycles into DIV -> no OUT_VALID, OUT_RESULT=0, IN_READY=1 next cycle; with ALU_SIGNED_CMP_EN, GT A=0x80,B=0x01 -> 0x00 (0x01 without).
